lzc_iter_ctrl: RTL and testbench



---
 rtl/lzc_iter_ctrl.sv | 111 +++++++++++
 tb/tb_lzc_iter_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lzc_iter_ctrl.sv
// Iterative leading-zero counter: scans a W-bit word MSB-first, one K-bit chunk
// per cycle, and returns the total leading-zero count over a valid/ready pair.
module lzc_iter_ctrl #(
    parameter int W = 32,
    parameter int K = 8,
    localparam int NC = W / K,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_zero,
    output logic          busy
);

    localparam int IW = $clog2(NC);
    localparam int KW = $clog2(K);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] count_q, count_d;
    logic          zero_q, zero_d;

    // Chunk 0 is the most significant K bits of the latched word.
    logic [K-1:0] chunks [NC];
    for (genvar g = 0; g < NC; g++) begin : g_chunk
        assign chunks[g] = data_q[W-1-g*K -: K];
    end

    logic [K-1:0]  chunk;
    logic [KW-1:0] lz;

    // Single K-bit LZC slice; the highest set bit is written last and wins.
    always_comb begin
        chunk = chunks[idx_q];
        lz    = '0;
        for (int b = 0; b < K; b++) begin
            if (chunk[b]) lz = KW'(K - 1 - b);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        count_d = count_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (chunk != '0) begin
                    // idx*K + lz with lz < K is exactly the concatenation.
                    count_d = CW'({idx_q, lz});
                    zero_d  = 1'b0;
                    state_d = DONE;
                end else if (idx_q == IW'(NC - 1)) begin
                    count_d = CW'(W);
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SCAN);
    assign out_count = count_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_iter_ctrl.sv
// Self-checking bench for lzc_iter_ctrl: directed vectors with literal
// expectations plus a transaction-level reference checked every cycle.
module tb_lzc_iter_ctrl;

    localparam int W  = 32;
    localparam int K  = 8;
    localparam int NC = W / K;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_count;
    logic        out_zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    lzc_iter_ctrl #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference count straight from the bit pattern, no chunking involved.
    function automatic int ref_lz(input logic [31:0] w);
        int n;
        n = W;
        for (int i = 0; i < W; i++) begin
            if (w[i]) n = W - 1 - i;
        end
        return n;
    endfunction

    // Transaction model: one word in flight, result due j+2 negedges after the
    // negedge preceding the accept edge.
    int          ncyc = 0;
    bit          pend = 1'b0;
    int          valid_at = 0;
    logic [5:0]  exp_cnt = '0;
    bit          exp_zero = 1'b0;
    logic [5:0]  last_cnt = '0;
    bit          last_zero = 1'b0;
    int          accepted = 0;
    int          m_lz;
    int          m_j;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_count", out_count, 0);
            check("rst_zero", out_zero, 0);
            pend      = 1'b0;
            last_cnt  = '0;
            last_zero = 1'b0;
        end else begin
            check("m_in_ready", in_ready, !pend);
            check("m_busy", busy, pend && ncyc < valid_at);
            check("m_out_valid", out_valid, pend && ncyc >= valid_at);
            if (pend && ncyc >= valid_at) begin
                check("m_count", out_count, exp_cnt);
                check("m_zero", out_zero, exp_zero);
            end else begin
                check("m_hold_count", out_count, last_cnt);
                check("m_hold_zero", out_zero, last_zero);
            end
            if (pend && ncyc >= valid_at && out_ready) begin
                pend      = 1'b0;
                last_cnt  = exp_cnt;
                last_zero = exp_zero;
            end else if (!pend && in_valid) begin
                m_lz     = ref_lz(in_data);
                m_j      = (m_lz >= W) ? NC - 1 : m_lz / K;
                exp_cnt  = 6'(m_lz);
                exp_zero = (m_lz == W);
                valid_at = ncyc + m_j + 2;
                pend     = 1'b1;
                accepted++;
            end
        end
    end

    // Called at posedge+1 with the block idle; exp_lat counts edges from the
    // accept edge to the first edge after which out_valid is high.
    task automatic run_word(input logic [31:0] w, input int exp_cnt_i, input bit exp_zero_i,
                            input int exp_lat, input int hold);
        int lat;
        int busy_n;
        check("pre_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~w;
        busy_n   = busy ? 1 : 0;
        lat      = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && busy) busy_n++;
        end while (!out_valid && lat < 2 * NC);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, exp_lat);
        check("count", out_count, exp_cnt_i);
        check("zero", out_zero, exp_zero_i);
        repeat (hold) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_count", out_count, exp_cnt_i);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_count", out_count, exp_cnt_i);
    endtask

    initial begin
        int start_acc;
        int cyc;
        int sh;
        logic [31:0] w;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        run_word(32'h8000_0000, 0, 0, 1, 0);
        run_word(32'h0000_1000, 19, 0, 3, 0);
        run_word(32'h0000_0001, 31, 0, 4, 0);
        run_word(32'h0000_0000, 32, 1, 4, 0);
        run_word(32'h00FF_0000, 8, 0, 2, 5);
        run_word(32'h4000_0000, 1, 0, 1, 0);

        // Reset while scanning an all-zero word at idx=2.
        in_valid = 1'b1;
        in_data  = 32'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_in_ready", in_ready, 0);
        check("mid_count", out_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        run_word(32'h0000_8000, 16, 0, 3, 0);

        // Random sweep; in_valid stays asserted through SCAN/DONE at times.
        start_acc = accepted;
        cyc = 0;
        while ((accepted - start_acc) < 10000 && cyc < 80000) begin
            @(posedge clk); #1;
            w  = $urandom;
            sh = $urandom_range(0, 33);
            in_data   = (sh >= 32) ? 32'h0 : (w >> sh);
            in_valid  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("sweep_words", (accepted - start_acc) >= 10000, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2 * NC + 2) @(posedge clk);
        #1;
        check("drain_in_ready", in_ready, 1);
        check("drain_out_valid", out_valid, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
